// File: rtl/cplx_sample_fifo.sv
// cplx_sample_fifo: first-word-fall-through staging FIFO for I/Q sample pairs
// feeding the MAC control FSM. A coefficient load (PushCoef) flushes all
// buffered samples so stale data never meets new coefficients.
//
// Optional feature macro: CPLX_FIFO_ERR_FLAGS_EN (sticky overflow/underflow
// flags cleared by ClearErr). When undefined the flags are tied low.
//
// Ports:
//   Clk, Reset          clock (rising edge), async active-high reset
//   PushIn              write strobe, DataInI/DataInQ sample pair
//   PushCoef            synchronous flush (highest priority)
//   fifo_PullOut        pop strobe from the MAC FSM
//   DataOutI/DataOutQ   head entry (valid while fifo_empty = 0)
//   fifo_empty/full     decoded from the count register
//   count               number of valid entries
//   ClearErr            clears sticky flags
//   overflow/underflow  sticky error flags
module cplx_sample_fifo #(
  parameter  int unsigned DW    = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          PushIn,
  input  logic [DW-1:0] DataInI,
  input  logic [DW-1:0] DataInQ,
  input  logic          PushCoef,
  input  logic          fifo_PullOut,
  output logic [DW-1:0] DataOutI,
  output logic [DW-1:0] DataOutQ,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic [CW-1:0] count,
  input  logic          ClearErr,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned EW = 2 * DW;

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_pull_acc;
  logic          w_push_acc;
  logic [EW-1:0] w_head;

  // Status decoded purely from the count register
  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(DEPTH));

  // Push into a full FIFO is allowed when the head is freed the same cycle
  assign w_pull_acc = fifo_PullOut && !w_empty;
  assign w_push_acc = PushIn && (!w_full || w_pull_acc);

  // Pointer and count update; flush wins over push/pull
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (PushCoef) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pull_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push_acc) - CW'(w_pull_acc);
    end
  end

  // Sample storage; contents survive a flush, only reset clears them
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push_acc && !PushCoef) begin
      r_mem[r_wr_ptr] <= {DataInI, DataInQ};
    end
  end

  // First-word-fall-through head
  assign w_head     = r_mem[r_rd_ptr];
  assign DataOutI   = w_head[EW-1:DW];
  assign DataOutQ   = w_head[DW-1:0];
  assign fifo_empty = w_empty;
  assign fifo_full  = w_full;
  assign count      = r_count;

`ifdef CPLX_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Error events are masked during a flush since push/pull are ignored then
  assign w_ovf_evt = !PushCoef && PushIn && !w_push_acc;
  assign w_udf_evt = !PushCoef && fifo_PullOut && w_empty;

  // Sticky flags; a new event outranks a coincident clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt)     r_overflow  <= 1'b1;
      else if (ClearErr) r_overflow  <= 1'b0;
      if (w_udf_evt)     r_underflow <= 1'b1;
      else if (ClearErr) r_underflow <= 1'b0;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  logic w_unused_clear_err;

  assign w_unused_clear_err = ClearErr;
  assign overflow           = 1'b0;
  assign underflow          = 1'b0;
`endif

endmodule

// File: doc/cplx_sample_fifo.md
# cplx_sample_fifo

Input staging FIFO for complex samples, sitting directly upstream of the MAC control FSM. It buffers I/Q sample pairs written by the input interface on `PushIn` and presents them to the MAC FSM in first-word-fall-through form. The MAC FSM reads `fifo_empty` and pops entries with `fifo_PullOut`. A coefficient load (`PushCoef`) flushes all buffered samples so stale data never meets new coefficients.

## Interface
- `DW`, 16, width of each of the I and Q components (two's complement).
- `DEPTH`, 8, number of entries; must be a power of 2, ≥ 2.

- `Clk`  in  1  clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `PushIn`  in  1  write strobe; one sample pair per cycle.
- `DataInI`  in  DW  real part of the incoming sample.
- `DataInQ`  in  DW  imaginary part of the incoming sample.
- `PushCoef`  in  1  coefficient load in progress; synchronous flush.
- `fifo_PullOut`  in  1  pop strobe from the MAC FSM.
- `DataOutI`  out  DW  real part of the head entry.
- `DataOutQ`  out  DW  imaginary part of the head entry.
- `fifo_empty`  out  1  no valid entries.
- `fifo_full`  out  1  DEPTH entries held.
- `count`  out  $clog2(DEPTH+1)  number of valid entries.
- `ClearErr`  in  1  clears the sticky error flags (only with CPLX_FIFO_ERR_FLAGS_EN).
- `overflow`  out  1  sticky flag: push dropped while full (only with CPLX_FIFO_ERR_FLAGS_EN).
- `underflow`  out  1  sticky flag: pull while empty (only with CPLX_FIFO_ERR_FLAGS_EN).

## Operation
- Storage is a DEPTH×(2·DW) register array.
- Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally DEPTH-1 → 0.
- `count` is a register.
  - `fifo_empty` = (count == 0).
  - `fifo_full` = (count == DEPTH).
  - Both are decoded from the `count` register only; no combinational path from any input.
- Head data is first-word-fall-through: `DataOutI`/`DataOutQ` = array[rd_ptr].
  - Value is meaningful only while `fifo_empty` = 0.
  - Value is don't-care when empty.
- Per-cycle priority, evaluated at the rising edge:
  1. `PushCoef` = 1: rd_ptr, wr_ptr and count go to 0. `PushIn` and `fifo_PullOut` are ignored that cycle. Array contents are not cleared.
  2. Otherwise, push is accepted if `PushIn` && (!full || pull accepted).
  3. Pull is accepted if `fifo_PullOut` && !empty.
  4. count += push_acc − pull_acc.
- Full + push + pull: both accepted; count stays DEPTH; the new entry is written into the slot being freed.
- Empty + push + pull: pull rejected, push accepted; count becomes 1.
- Push while full without a pull: data is dropped; pointers and count are unchanged.
- Pull while empty: no state change.
- Reset mid-operation discards all entries immediately (asynchronous).

## Timing
- Reset values:
  - count = 0, fifo_empty = 1, fifo_full = 0.
  - overflow = 0, underflow = 0, pointers = 0.
  - DataOutI/Q = 0 (array reset to 0).
- Push latency: a push sampled at edge N sets `fifo_empty` = 0 and presents the data on DataOut after edge N, i.e. in cycle N+1.
- Pull latency: a pull sampled at edge N advances DataOut to the next entry after edge N.
- Back-to-back pulls are supported every cycle, so the MAC FSM may pop on consecutive cycles.
- `fifo_PullOut` asserted in the same cycle that `fifo_empty` falls is legal and pops that entry.
- Flush: a `PushCoef` sampled at edge N gives `fifo_empty` = 1 from cycle N+1.
- Throughput: 1 push and 1 pull per cycle.

## Configuration
- Macro: `CPLX_FIFO_ERR_FLAGS_EN`.
- Defined:
  - `overflow` sets on a dropped push; `underflow` sets on a rejected pull.
  - Both flags stay set until `ClearErr` or `Reset`.
  - `ClearErr` takes effect at the next edge. If it coincides with a new error event, the flag stays set.
  - A flush does not clear the flags.
- Undefined:
  - `overflow` and `underflow` are tied to 0.
  - `ClearErr` is ignored.
  - No flag registers are synthesized.
  - All data-path behaviour is identical to the defined case.

## Test plan
- **Reset, then single sample:** push I=0x1234, Q=0xFEDC.
  - Cycle after: fifo_empty = 0, count = 1, DataOut = 0x1234/0xFEDC.
  - Pull: fifo_empty = 1 the next cycle.
- **Fill to full:** 8 pushes of I=k, Q=−k.
  - fifo_full = 1 and count = 8 after the 8th push.
  - 9th push (I=99) is dropped; with the macro, overflow = 1.
  - 8 pulls return k = 0..7 in order.
- **Simultaneous push+pull when full:** the head pops, the new entry is accepted, count stays 8.
  - Subsequent drain order is preserved.
- **Wrap-around:** 3 pushes, 3 pulls, then 7 pushes (wr_ptr wraps).
  - Drain returns the 7 values in order and count reaches 0.
- **Flush:** 5 entries held, assert PushCoef together with PushIn and fifo_PullOut.
  - Next cycle: count = 0, fifo_empty = 1, the push is discarded.
  - overflow/underflow are unchanged.
- **Underflow and async reset:**
  - Pull while empty: count stays 0; with the macro, underflow = 1.
  - ClearErr: underflow = 0.
  - Assert Reset mid-cycle with 4 entries held: count = 0 and fifo_empty = 1 immediately, without waiting for a clock edge.
